// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the character-ROM arbiter slice.
package rom_arb_pkg;
  localparam int unsigned ROM_ADDR_W   = 4;
  localparam int unsigned ROM_DATA_W   = 8;
  localparam int unsigned READ_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W    = $clog2(READ_LAT_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} rom_arb_state_t;
endpackage

// File: rtl/rom_rr_pick.sv
// Two-way round-robin picker: on a tie, the client that did not win last time wins.
module rom_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx   = (req == 2'b11) ? ~last_grant : req[1];
endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter and read sequencer placing two clients onto one synchronous ROM.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ROM_ADDR_W,
  parameter int unsigned DATA_W   = ROM_DATA_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] ROM_addr,
  output logic              ROM_re,
  output logic              ROM_ce,
  input  logic [DATA_W-1:0] ROM_data
);
  rom_arb_state_t       state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_q, grant_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rdata0_q, rdata0_d;
  logic [DATA_W-1:0]    rdata1_q, rdata1_d;
  logic                 gnt_valid, gnt_idx;

  rom_rr_pick u_pick (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d      = gnt_idx;
          last_grant_d = gnt_idx;
          addr_d       = gnt_idx ? addr1 : addr0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_CNT_W'(READ_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (grant_q) rdata1_d = ROM_data;
          else         rdata0_d = ROM_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes depend only on registered state so client inputs never reach the pins.
  always_comb begin
    ROM_ce = 1'b0;
    ROM_re = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    busy   = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        ROM_ce = 1'b1;
        ROM_re = 1'b1;
      end
      RESP: begin
        ack0 = ~grant_q;
        ack1 = grant_q;
      end
      default: ;
    endcase
  end

  assign ROM_addr = addr_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and read sequencer for the shared 16x8 character ROM. It accepts read requests from two independent clients, such as the sensor controller and a display or debug client, and grants them round-robin. It drives the ROM chip-enable, read-enable and address pins, then returns each word to its requester with a one-cycle acknowledge. The block sits between the clients and `rom` in `top`, and runs on the same clock as the ROM.

## Interface
Parameters:
- `ADDR_W`, 4, ROM address width.
- `DATA_W`, 8, ROM data width.
- `READ_LAT`, 1, cycles from the ROM sampling `ce&re` to `ROM_data` being valid. Legal range is 1..4.

Ports:
- `clk` input 1: single system clock; the ROM is clocked by the same net.
- `reset_n` input 1: asynchronous, active-low reset.
- `req0` input 1: client 0 read request, level-held until `ack0`.
- `addr0` input ADDR_W: client 0 address, stable while `req0` is high.
- `ack0` output 1: one-cycle pulse; `rdata0` is valid in this cycle.
- `rdata0` output DATA_W: client 0 read data, held until the next `ack0`.
- `req1`, `addr1`, `ack1`, `rdata1`: same as above, for client 1.
- `busy` output 1: high whenever the state is not IDLE.
- `ROM_addr` output ADDR_W: ROM address.
- `ROM_re` output 1: ROM read enable.
- `ROM_ce` output 1: ROM chip enable.
- `ROM_data` input DATA_W: ROM data output.

## Operation
- Reset values: state IDLE, all outputs 0, `last_grant`=1 (so client 0 wins the first tie), latency counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples `req0` and `req1`.
  - One request high: grant that client.
  - Both high: grant the client that is not `last_grant`.
  - On a grant: latch the grant index and the address, update `last_grant`, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - Exactly one cycle with `ROM_ce`=`ROM_re`=1 and `ROM_addr` set to the latched address.
  - Load the counter with READ_LAT-1 and go to WAIT.
- WAIT:
  - `ROM_ce` and `ROM_re` are 0; `ROM_addr` holds its value.
  - Decrement the counter each cycle.
  - In the cycle where the counter is 0, `ROM_data` is valid: capture it into the granted client's `rdata` register and go to RESP.
- RESP:
  - `ack` is high for the granted client only; its `rdata` already holds the new word.
  - Always return to IDLE; there is no direct RESP-to-ISSUE path.
- A client whose `req` is still high in the IDLE cycle after its ack has made a new request and is arbitrated normally.
- The other client's `rdata` is never modified.
- `ROM_ce` and `ROM_re` are 0 in every state except ISSUE, which saves ROM power.
- Protocol violations:
  - `req` dropped before ack: the transaction still completes and the ack is still issued.
  - `addr` changed after the grant: ignored, because the address was already latched.
- Both acks are never high in the same cycle.
- `ack` and `ROM_*` are decoded from registered state and latched fields only; there are no combinational paths from `req`/`addr` to outputs.

## Timing
- A request sampled in IDLE at cycle 0 produces:
  - ISSUE at cycle 1;
  - data capture at cycle 1+READ_LAT;
  - ack at cycle 2+READ_LAT.
- With the default READ_LAT=1, ack arrives 3 cycles after the sampling edge.
- Throughput: one transaction per READ_LAT+3 cycles; two contending clients alternate strictly.
- A request arriving during ISSUE, WAIT or RESP waits for the next IDLE.
- Worst-case wait for a granted request is one full transaction of the other client plus its own transaction.
- Reset asserted mid-transaction:
  - all outputs go to 0 immediately (asynchronous);
  - the in-flight read is discarded with no ack;
  - after release, the FSM restarts in IDLE with `last_grant`=1.

## Structure
- Package `rom_arb_pkg` holds:
  - the state enum `rom_arb_state_t` (IDLE, ISSUE, WAIT, RESP);
  - default widths `ROM_ADDR_W`=4 and `ROM_DATA_W`=8;
  - the width of the latency counter, set by `READ_LAT_MAX`=4.
- Sub-module `rom_rr_pick`: combinational two-way round-robin picker. Inputs are `req[1:0]` and `last_grant`; outputs are `gnt_valid` and `gnt_idx`. The arbiter instantiates it once in IDLE decode.
- The FSM, latency counter, address/grant latches and `rdata` registers live in `rom_arbiter`.

## Test plan
The bench uses a behavioural ROM model returning `{addr, ~addr}` after READ_LAT cycles.
- Single read, READ_LAT=1: `req0` with `addr0`=4'h3 at cycle 0 -> `ROM_ce`/`ROM_re` high only in cycle 1 with `ROM_addr`=3; `ack0` in cycle 3 with `rdata0`=8'h3C; `ack1` stays 0.
- Simultaneous requests after reset: `req0` `addr0`=4'hA and `req1` `addr1`=4'h5 at cycle 0 -> `ack0`=8'hA5 at cycle 3, then `ack1`=8'h5A at cycle 7.
- Sustained contention: both `req` held for 8 transactions -> acks alternate 0,1,0,1 with exactly 4 cycles between acks; never both in one cycle.
- READ_LAT=3 build: `req1` `addr1`=4'hF -> ack at cycle 5 with `rdata1`=8'hF0; `ROM_ce` high for exactly one cycle.
- Reset mid-WAIT: assert `reset_n`=0 in cycle 2 of a `req0` read -> all outputs 0 immediately; no ack after release; a fresh `req0` `addr0`=4'h1 acks 8'h1E at 3 cycles.
- Early drop: `req0` falls in cycle 1 -> `ack0` still asserted in cycle 3; `rdata1` unchanged.
